// File: rtl/cr_kme_fifo_arb_pkg.sv
// Shared types and helpers for the cr_kme FIFO write-port arbiter.
// Provides the arbiter state enum, index-width helper and default starve limit.
package cr_kme_fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int STARVE_LIMIT_DEF = 64;

  function automatic int ARB_IDX_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cr_kme_rr_pick.sv
// Rotate-priority picker: first set bit of req searching from ptr upward.
// Ports: req/ptr in; onehot/idx/any out (all zero when nothing requested).
module cr_kme_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Scan farthest-first so the nearest hit to ptr is the last write.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = IW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_kme_fifo_wr_arb.sv
// Round-robin, packet-locking arbiter sharing one cr_kme FIFO write port.
// Ports: req_valid/eop/data in, req_ack out; fifo_in/valid out, fifo_in_stall in;
// grant_id, lock_active, starve status out.
module cr_kme_fifo_wr_arb
  import cr_kme_fifo_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 263,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  localparam int IW          = ARB_IDX_W(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_eop,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]       fifo_in,
  output logic                    fifo_in_valid,
  input  logic                    fifo_in_stall,
  output logic [IW-1:0]           grant_id,
  output logic                    lock_active,
  output logic [N_REQ-1:0]        starve
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0] pick_idx;
  logic pick_any;
  logic [IW-1:0] winner;
  logic elig;
  logic [N_REQ-1:0] ack_oh;
  logic [N_REQ-1:0][CW-1:0] cnt_q;

  cr_kme_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // While locked only the owner may win; others see no ack at all.
  always_comb begin
    winner = pick_idx;
    elig   = pick_any;
    ack_oh = pick_oh;
    if (state_q == LOCKED) begin
      winner          = owner_q;
      elig            = req_valid[owner_q];
      ack_oh          = '0;
      ack_oh[owner_q] = 1'b1;
    end
  end

  assign fifo_in_valid = elig && !fifo_in_stall;
  assign req_ack       = ack_oh & {N_REQ{fifo_in_valid}};
  assign fifo_in       = req_data[winner*DATA_W +: DATA_W];
  assign grant_id      = winner;
  assign lock_active   = (state_q == LOCKED);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (fifo_in_valid) begin
      if (req_eop[winner]) begin
        state_d  = IDLE;
        rr_ptr_d = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
      end else begin
        state_d = LOCKED;
        owner_d = winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] || req_ack[i])
          cnt_q[i] <= '0;
        else if (cnt_q[i] != CW'(STARVE_LIMIT))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    starve = '0;
    for (int i = 0; i < N_REQ; i++)
      starve[i] = (cnt_q[i] == CW'(STARVE_LIMIT));
  end

endmodule

// File: tb/tb_cr_kme_fifo_wr_arb.sv
// Directed bench for cr_kme_fifo_wr_arb: round robin, lock, stall,
// bubbles, starvation and mid-packet reset, plus per-cycle invariants.
module tb_cr_kme_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 263;
  localparam int SL = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_eop;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   fifo_in;
  logic            fifo_in_valid;
  logic            fifo_in_stall;
  logic [1:0]      grant_id;
  logic            lock_active;
  logic [N-1:0]    starve;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cr_kme_fifo_wr_arb #(
    .N_REQ        (N),
    .DATA_W       (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_eop       (req_eop),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .fifo_in       (fifo_in),
    .fifo_in_valid (fifo_in_valid),
    .fifo_in_stall (fifo_in_stall),
    .grant_id      (grant_id),
    .lock_active   (lock_active),
    .starve        (starve)
  );

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int i, input int b);
    logic [DW-1:0] d;
    d = '0;
    d[DW-1 -: 8] = 8'(8'hC0 + i);
    d[31:0] = 32'(i * 256 + b);
    d[150 +: 16] = 16'(16'hBEEF ^ ((i << 4) | b));
    return d;
  endfunction

  task automatic setd(input int i, input int b);
    req_data[i*DW +: DW] = mk(i, b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("mon_ack_1hot0", DW'($onehot0(req_ack)), DW'(1));
      check("mon_stall", DW'(fifo_in_valid && fifo_in_stall), DW'(0));
      if (lock_active && |req_ack)
        check("mon_lock_owner", DW'(req_ack), DW'(4'b1 << grant_id));
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_eop = '0;
    req_data = '0;
    fifo_in_stall = 1'b0;
    for (int i = 0; i < N; i++) setd(i, 0);

    @(negedge clk);
    check("rst_ack", DW'(req_ack), DW'(0));
    check("rst_fiv", DW'(fifo_in_valid), DW'(0));
    check("rst_lock", DW'(lock_active), DW'(0));
    check("rst_starve", DW'(starve), DW'(0));
    check("rst_gid", DW'(grant_id), DW'(0));
    tick();
    rst_n = 1'b1;

    req_valid = 4'hF;
    req_eop = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t1_ack", DW'(req_ack), DW'(4'b1 << (k % 4)));
      check("t1_gid", DW'(grant_id), DW'(k % 4));
      check("t1_data", fifo_in, mk(k % 4, 0));
      check("t1_fiv", DW'(fifo_in_valid), DW'(1));
      tick();
    end

    req_valid = 4'b0111;
    req_eop = 4'b0101;
    setd(1, 1);
    @(negedge clk);
    check("t2_ack_b1", DW'(req_ack), DW'(4'b0010));
    check("t2_lock_b1", DW'(lock_active), DW'(0));
    check("t2_data_b1", fifo_in, mk(1, 1));
    tick();
    setd(1, 2);
    @(negedge clk);
    check("t2_ack_b2", DW'(req_ack), DW'(4'b0010));
    check("t2_lock_b2", DW'(lock_active), DW'(1));
    check("t2_data_b2", fifo_in, mk(1, 2));
    tick();
    setd(1, 3);
    req_eop = 4'b0111;
    @(negedge clk);
    check("t2_ack_b3", DW'(req_ack), DW'(4'b0010));
    check("t2_lock_b3", DW'(lock_active), DW'(1));
    check("t2_data_b3", fifo_in, mk(1, 3));
    tick();
    @(negedge clk);
    check("t2_ack_next", DW'(req_ack), DW'(4'b0100));
    check("t2_lock_next", DW'(lock_active), DW'(0));
    tick();
    req_valid = '0;

    @(negedge clk);
    check("t3_idle_fiv", DW'(fifo_in_valid), DW'(0));
    tick();
    req_valid = 4'hF;
    req_eop = 4'hF;
    fifo_in_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_stall_fiv", DW'(fifo_in_valid), DW'(0));
      check("t3_stall_ack", DW'(req_ack), DW'(0));
      check("t3_stall_gid", DW'(grant_id), DW'(3));
      tick();
    end
    fifo_in_stall = 1'b0;
    @(negedge clk);
    check("t3_rel_ack", DW'(req_ack), DW'(4'b1000));
    check("t3_rel_fiv", DW'(fifo_in_valid), DW'(1));
    tick();
    req_valid = '0;

    @(negedge clk);
    tick();
    req_valid = 4'b1001;
    req_eop = 4'b1000;
    setd(0, 1);
    @(negedge clk);
    check("t4_ack_first", DW'(req_ack), DW'(4'b0001));
    tick();
    req_valid = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t4_bub_ack", DW'(req_ack), DW'(0));
      check("t4_bub_fiv", DW'(fifo_in_valid), DW'(0));
      check("t4_bub_lock", DW'(lock_active), DW'(1));
      check("t4_bub_gid", DW'(grant_id), DW'(0));
      tick();
    end
    req_valid = 4'b1001;
    req_eop = 4'b1001;
    setd(0, 2);
    @(negedge clk);
    check("t4_res_ack", DW'(req_ack), DW'(4'b0001));
    check("t4_res_data", fifo_in, mk(0, 2));
    check("t4_res_lock", DW'(lock_active), DW'(1));
    tick();
    @(negedge clk);
    check("t4_r3_ack", DW'(req_ack), DW'(4'b1000));
    check("t4_r3_starve", DW'(starve), DW'(4'b1000));
    tick();
    req_valid = '0;

    @(negedge clk);
    tick();
    fifo_in_stall = 1'b1;
    req_valid = 4'b0001;
    req_eop = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_starve", DW'(starve), DW'((k >= SL) ? 4'b0001 : 4'b0000));
      check("t5_ack", DW'(req_ack), DW'(0));
      tick();
    end
    fifo_in_stall = 1'b0;
    @(negedge clk);
    check("t5_rel_ack", DW'(req_ack), DW'(4'b0001));
    check("t5_rel_starve", DW'(starve), DW'(4'b0001));
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t5_clr_starve", DW'(starve), DW'(0));
    tick();

    req_valid = 4'b0100;
    req_eop = 4'b0000;
    @(negedge clk);
    check("t6_ack", DW'(req_ack), DW'(4'b0100));
    tick();
    @(negedge clk);
    check("t6_lock", DW'(lock_active), DW'(1));
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("t6_rst_lock", DW'(lock_active), DW'(0));
    check("t6_rst_ack", DW'(req_ack), DW'(0));
    check("t6_rst_gid", DW'(grant_id), DW'(0));
    check("t6_rst_starve", DW'(starve), DW'(0));
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1001;
    req_eop = 4'b1001;
    @(negedge clk);
    check("t6_post_ack", DW'(req_ack), DW'(4'b0001));
    check("t6_post_gid", DW'(grant_id), DW'(0));
    check("t6_post_lock", DW'(lock_active), DW'(0));
    tick();
    req_valid = '0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
